// File: rtl/sram_bus_arbiter.sv
// Shares one asynchronous SRAM between the IF (read-only) and MEM (read/write) ports,
// with fixed MEM-over-IF priority and multi-cycle strobe sequencing.
module sram_bus_arbiter #(
    parameter int ADDR_W   = 18,
    parameter int RD_WAIT  = 1,
    parameter int WR_PULSE = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [15:0]       if_addr,
    output logic [15:0]       if_rdata,
    output logic              if_ready,
    output logic              if_stall,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [15:0]       mem_addr,
    input  logic [15:0]       mem_wdata,
    output logic [15:0]       mem_rdata,
    output logic              mem_ready,
    output logic              mem_stall,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [15:0]       ram_data_o,
    input  logic [15:0]       ram_data_i,
    output logic              ram_data_oe,
    output logic              ram_ce_n,
    output logic              ram_oe_n,
    output logic              ram_we_n
);
    localparam int MAX_WAIT = (RD_WAIT > WR_PULSE) ? RD_WAIT : WR_PULSE;
    localparam int CNT_W    = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(RD_WAIT - 1);
    localparam logic [CNT_W-1:0] WR_LAST = CNT_W'(WR_PULSE - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_DONE
    } state_t;

    typedef enum logic [1:0] {OWN_NONE, OWN_IF, OWN_MEM} owner_t;

    state_t            state_reg, state_next;
    owner_t            owner_reg, owner_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [15:0]       addr_reg, addr_next;
    logic [15:0]       wdata_reg, wdata_next;
    logic [15:0]       if_rdata_reg, if_rdata_next;
    logic [15:0]       mem_rdata_reg, mem_rdata_next;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= S_IDLE;
            owner_reg     <= OWN_NONE;
            cnt_reg       <= '0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            if_rdata_reg  <= '0;
            mem_rdata_reg <= '0;
        end else begin
            state_reg     <= state_next;
            owner_reg     <= owner_next;
            cnt_reg       <= cnt_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            if_rdata_reg  <= if_rdata_next;
            mem_rdata_reg <= mem_rdata_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        owner_next     = owner_reg;
        cnt_next       = cnt_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        if_rdata_next  = if_rdata_reg;
        mem_rdata_next = mem_rdata_reg;
        ram_ce_n       = 1'b1;
        ram_oe_n       = 1'b1;
        ram_we_n       = 1'b1;
        ram_data_oe    = 1'b0;
        if_ready       = 1'b0;
        mem_ready      = 1'b0;

        case (state_reg)
            S_IDLE: begin
                cnt_next = '0;
                if (mem_req) begin
                    owner_next = OWN_MEM;
                    addr_next  = mem_addr;
                    wdata_next = mem_wdata;
                    state_next = mem_we ? S_WR_SETUP : S_RD;
                end else if (if_req) begin
                    owner_next = OWN_IF;
                    addr_next  = if_addr;
                    state_next = S_RD;
                end
            end
            S_RD: begin
                ram_ce_n = 1'b0;
                ram_oe_n = 1'b0;
                if (cnt_reg == RD_LAST) begin
                    state_next = S_DONE;
                    if (owner_reg == OWN_MEM) begin
                        mem_rdata_next = ram_data_i;
                    end else begin
                        if_rdata_next = ram_data_i;
                    end
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            S_WR_SETUP: begin
                ram_ce_n    = 1'b0;
                ram_data_oe = 1'b1;
                cnt_next    = '0;
                state_next  = S_WR_PULSE;
            end
            S_WR_PULSE: begin
                ram_ce_n    = 1'b0;
                ram_data_oe = 1'b1;
                ram_we_n    = 1'b0;
                if (cnt_reg == WR_LAST) begin
                    state_next = S_WR_HOLD;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            S_WR_HOLD: begin
                ram_ce_n    = 1'b0;
                ram_data_oe = 1'b1;
                state_next  = S_DONE;
            end
            S_DONE: begin
                // Owner is kept through DONE so the stall terms can see who finished.
                if_ready   = (owner_reg == OWN_IF);
                mem_ready  = (owner_reg == OWN_MEM);
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign if_stall   = if_req  & ~((state_reg == S_DONE) && (owner_reg == OWN_IF));
    assign mem_stall  = mem_req & ~((state_reg == S_DONE) && (owner_reg == OWN_MEM));
    assign if_rdata   = if_rdata_reg;
    assign mem_rdata  = mem_rdata_reg;
    assign ram_data_o = wdata_reg;

    // Word address is zero-extended onto the wider SRAM address bus.
    for (genvar gi = 0; gi < ADDR_W; gi++) begin : g_addr
        if (gi < 16) begin : g_lo
            assign ram_addr[gi] = addr_reg[gi];
        end else begin : g_hi
            assign ram_addr[gi] = 1'b0;
        end
    end
endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: per-cycle vector table, hand-written corner sequences,
// and a ready/rdata scoreboard fed when requests are issued.
module tb_sram_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, mem_req, mem_we;
    logic [15:0] if_addr, mem_addr, mem_wdata, ram_data_i;
    logic [15:0] if_rdata, mem_rdata, ram_data_o;
    logic        if_ready, if_stall, mem_ready, mem_stall;
    logic [17:0] ram_addr;
    logic        ram_data_oe, ram_ce_n, ram_oe_n, ram_we_n;

    // second instance with RD_WAIT = 2, IF traffic only
    logic        if_req2;
    logic [15:0] if_addr2 = 16'h0300;
    logic        mem_req2 = 1'b0, mem_we2 = 1'b0;
    logic [15:0] mem_addr2 = 16'h0, mem_wdata2 = 16'h0, ram_data_i2;
    logic [15:0] if_rdata2, mem_rdata2, ram_data_o2;
    logic        if_ready2, if_stall2, mem_ready2, mem_stall2;
    logic [17:0] ram_addr2;
    logic        ram_data_oe2, ram_ce_n2, ram_oe_n2, ram_we_n2;

    always #5 clk = ~clk;

    sram_bus_arbiter #(.ADDR_W(18), .RD_WAIT(1), .WR_PULSE(1)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready), .if_stall(if_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_stall(mem_stall),
        .ram_addr(ram_addr), .ram_data_o(ram_data_o), .ram_data_i(ram_data_i),
        .ram_data_oe(ram_data_oe), .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n)
    );

    sram_bus_arbiter #(.ADDR_W(18), .RD_WAIT(2), .WR_PULSE(1)) dut2 (
        .clk(clk), .rst(rst),
        .if_req(if_req2), .if_addr(if_addr2), .if_rdata(if_rdata2), .if_ready(if_ready2), .if_stall(if_stall2),
        .mem_req(mem_req2), .mem_we(mem_we2), .mem_addr(mem_addr2), .mem_wdata(mem_wdata2),
        .mem_rdata(mem_rdata2), .mem_ready(mem_ready2), .mem_stall(mem_stall2),
        .ram_addr(ram_addr2), .ram_data_o(ram_data_o2), .ram_data_i(ram_data_i2),
        .ram_data_oe(ram_data_oe2), .ram_ce_n(ram_ce_n2), .ram_oe_n(ram_oe_n2), .ram_we_n(ram_we_n2)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } sb_t;

    sb_t if_q[$];
    sb_t mem_q[$];
    sb_t if2_q[$];

    // A ready is expected exactly in the cycle recorded when the request was issued.
    always @(posedge clk) begin
        sb_t  e;
        logic er;
        #3;
        er = (if_q.size() > 0) && (if_q[0].cyc == cyc);
        if (if_ready || er) begin
            chk("if_ready", if_ready, er);
            if (er) begin
                e = if_q.pop_front();
                if (if_ready) chk("if_rdata", if_rdata, e.data);
            end
        end
        er = (mem_q.size() > 0) && (mem_q[0].cyc == cyc);
        if (mem_ready || er) begin
            chk("mem_ready", mem_ready, er);
            if (er) begin
                e = mem_q.pop_front();
                if (mem_ready) chk("mem_rdata", mem_rdata, e.data);
            end
        end
        er = (if2_q.size() > 0) && (if2_q[0].cyc == cyc);
        if (if_ready2 || er) begin
            chk("if_ready2", if_ready2, er);
            if (er) begin
                e = if2_q.pop_front();
                if (if_ready2) chk("if_rdata2", if_rdata2, e.data);
            end
        end
    end

    typedef struct {
        logic        if_req;
        logic [15:0] if_addr;
        logic        mem_req, mem_we;
        logic [15:0] mem_addr, mem_wdata, rdi;
        logic        ce_n, oe_n, we_n, doe;
        logic [17:0] addr;
        logic [15:0] wdo;
        logic        addr_dc, wdo_dc;
        logic        if_ready, mem_ready;
        logic [15:0] if_rdata, mem_rdata;
        logic        if_stall, mem_stall;
        int          push;      // 0 none, 1 IF, 2 MEM
        logic [15:0] push_data;
        int          push_lat;
    } vec_t;

    vec_t vt[10];

    function automatic logic [15:0] pat(input int c);
        return 16'h2000 ^ 16'(c * 37);
    endfunction

    initial begin
        int          c0;
        logic [73:0] act, exp;

        //            ifr  if_addr     mr we mem_addr  wdata     rdi        ce oe we doe addr       wdo       adc wdc ifr mr if_rdata  mem_rd    ifs ms push data      lat
        vt[0] = '{1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 16'h4A01, 1, 1, 1, 0, 18'h0,     16'h0,    1, 1, 0, 0, 16'h0000, 16'h0000, 1, 0, 1, 16'h4A01, 2};
        vt[1] = '{1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 16'h4A01, 0, 0, 1, 0, 18'h00010, 16'h0,    0, 1, 0, 0, 16'h0000, 16'h0000, 1, 0, 0, 16'h0,    0};
        vt[2] = '{1, 16'h0010, 0, 0, 16'h0000, 16'h0000, 16'h4A01, 1, 1, 1, 0, 18'h0,     16'h0,    1, 1, 1, 0, 16'h4A01, 16'h0000, 0, 0, 0, 16'h0,    0};
        vt[3] = '{0, 16'h0010, 0, 0, 16'h0000, 16'h0000, 16'h4A01, 1, 1, 1, 0, 18'h0,     16'h0,    1, 1, 0, 0, 16'h4A01, 16'h0000, 0, 0, 0, 16'h0,    0};
        vt[4] = '{0, 16'h0000, 1, 1, 16'h8000, 16'h1234, 16'h0000, 1, 1, 1, 0, 18'h0,     16'h0,    1, 1, 0, 0, 16'h4A01, 16'h0000, 0, 1, 2, 16'h0000, 4};
        vt[5] = '{0, 16'h0000, 1, 1, 16'h8000, 16'h1234, 16'h0000, 0, 1, 1, 1, 18'h08000, 16'h1234, 0, 0, 0, 0, 16'h4A01, 16'h0000, 0, 1, 0, 16'h0,    0};
        vt[6] = '{0, 16'h0000, 1, 1, 16'h8000, 16'h1234, 16'h0000, 0, 1, 0, 1, 18'h08000, 16'h1234, 0, 0, 0, 0, 16'h4A01, 16'h0000, 0, 1, 0, 16'h0,    0};
        vt[7] = '{0, 16'h0000, 1, 1, 16'h8000, 16'h1234, 16'h0000, 0, 1, 1, 1, 18'h08000, 16'h1234, 0, 0, 0, 0, 16'h4A01, 16'h0000, 0, 1, 0, 16'h0,    0};
        vt[8] = '{0, 16'h0000, 1, 1, 16'h8000, 16'h1234, 16'h0000, 1, 1, 1, 0, 18'h0,     16'h0,    1, 1, 0, 1, 16'h4A01, 16'h0000, 0, 0, 0, 16'h0,    0};
        vt[9] = '{0, 16'h0000, 0, 1, 16'h8000, 16'h1234, 16'h0000, 1, 1, 1, 0, 18'h0,     16'h0,    1, 1, 0, 0, 16'h4A01, 16'h0000, 0, 0, 0, 16'h0,    0};

        // reset with both requests raised
        rst = 1'b0; if_req = 1'b1; mem_req = 1'b1; mem_we = 1'b0;
        if_addr = 16'h1111; mem_addr = 16'h2222; mem_wdata = 16'h3333; ram_data_i = 16'h0;
        if_req2 = 1'b0; ram_data_i2 = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ce_n", ram_ce_n, 1'b1);
        chk("rst_oe_n", ram_oe_n, 1'b1);
        chk("rst_we_n", ram_we_n, 1'b1);
        chk("rst_data_oe", ram_data_oe, 1'b0);
        chk("rst_ram_addr", ram_addr, 18'h0);
        chk("rst_ram_data_o", ram_data_o, 16'h0);
        chk("rst_if_ready", if_ready, 1'b0);
        chk("rst_mem_ready", mem_ready, 1'b0);
        chk("rst_if_rdata", if_rdata, 16'h0);
        chk("rst_mem_rdata", mem_rdata, 16'h0);
        chk("rst_if_stall", if_stall, 1'b1);
        chk("rst_mem_stall", mem_stall, 1'b1);
        if_req = 1'b0; mem_req = 1'b0; rst = 1'b1;
        step();

        // IF read of 0x0010 followed by MEM write of 0x1234 to 0x8000
        for (int i = 0; i < 10; i++) begin
            step();
            if_req = vt[i].if_req; if_addr = vt[i].if_addr;
            mem_req = vt[i].mem_req; mem_we = vt[i].mem_we;
            mem_addr = vt[i].mem_addr; mem_wdata = vt[i].mem_wdata; ram_data_i = vt[i].rdi;
            if (vt[i].push == 1) if_q.push_back('{vt[i].push_data, cyc + vt[i].push_lat});
            if (vt[i].push == 2) mem_q.push_back('{vt[i].push_data, cyc + vt[i].push_lat});
            #1;
            exp = {vt[i].ce_n, vt[i].oe_n, vt[i].we_n, vt[i].doe,
                   vt[i].addr_dc ? 18'h0 : vt[i].addr, vt[i].wdo_dc ? 16'h0 : vt[i].wdo,
                   vt[i].if_ready, vt[i].mem_ready, vt[i].if_rdata, vt[i].mem_rdata,
                   vt[i].if_stall, vt[i].mem_stall};
            act = {ram_ce_n, ram_oe_n, ram_we_n, ram_data_oe,
                   vt[i].addr_dc ? 18'h0 : ram_addr, vt[i].wdo_dc ? 16'h0 : ram_data_o,
                   if_ready, mem_ready, if_rdata, mem_rdata, if_stall, mem_stall};
            chk($sformatf("vec%0d", i), act, exp);
        end

        // simultaneous IF read 0x0020 and MEM read 0x0100: MEM wins
        step();
        c0 = cyc;
        if_req = 1'b1; if_addr = 16'h0020;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h0100; ram_data_i = 16'hBEEF;
        mem_q.push_back('{16'hBEEF, c0 + 2});
        if_q.push_back('{16'hC0DE, c0 + 5});
        #1;
        chk("sim_if_stall_c0", if_stall, 1'b1);
        for (int t = 1; t <= 6; t++) begin
            step();
            if (t == 3) begin mem_req = 1'b0; ram_data_i = 16'hC0DE; end
            if (t == 6) if_req = 1'b0;
            #1;
            if (t <= 4) chk($sformatf("sim_if_stall_c%0d", t), if_stall, 1'b1);
            if (t == 5) chk("sim_if_stall_c5", if_stall, 1'b0);
            if (t == 2) chk("sim_mem_stall_c2", mem_stall, 1'b0);
            if (t == 1) chk("sim_mem_rd", {ram_addr, ram_oe_n, ram_ce_n}, {18'h00100, 1'b0, 1'b0});
            if (t == 4) chk("sim_if_rd", {ram_addr, ram_oe_n, ram_ce_n}, {18'h00020, 1'b0, 1'b0});
        end

        // reset while WE is pulsed: access aborted, no mem_ready
        step();
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 16'h0042; mem_wdata = 16'h5555;
        step();
        #1 chk("abort_setup_oe", ram_data_oe, 1'b1);
        step();
        #1 chk("abort_pulse_we_n", ram_we_n, 1'b0);
        rst = 1'b0; mem_req = 1'b0;
        step();
        rst = 1'b1;
        #1;
        chk("abort_strobes", {ram_we_n, ram_data_oe, ram_ce_n, ram_oe_n}, 4'b1011);
        chk("abort_ram_data_o", ram_data_o, 16'h0);
        chk("abort_mem_rdata", mem_rdata, 16'h0);
        step();
        step();
        c0 = cyc;
        if_req = 1'b1; if_addr = 16'h0077; ram_data_i = 16'h1357;
        if_q.push_back('{16'h1357, c0 + 2});
        step();
        #1 chk("post_rst_if_rd", {ram_addr, ram_oe_n}, {18'h00077, 1'b0});
        step();
        step();
        if_req = 1'b0;

        // back-to-back IF reads with req held, RD_WAIT = 2
        step();
        c0 = cyc;
        if_req2 = 1'b1;
        for (int k = 0; k < 3; k++) if2_q.push_back('{pat(c0 + 2 + 4 * k), c0 + 3 + 4 * k});
        for (int t = 0; t <= 12; t++) begin
            if (t > 0) step();
            ram_data_i2 = pat(cyc);
            if (t == 12) if_req2 = 1'b0;
            if (t == 3) begin
                #1 chk("b2b_if_stall2_ready", if_stall2, 1'b0);
            end
            if (t == 4) begin
                #1 chk("b2b_if_stall2_idle", if_stall2, 1'b1);
            end
        end

        repeat (4) step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
